seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
Parametrised, registered successor of the stack CPU's 8-bit combinational ALU. Adds operand width parameter, 3-bit opcode (original four ops keep their codes), registered result plus zero/carry/negative flags, and a multi-cycle shift-add multiply under a start/busy/done handshake. Sits between the stack-top operand registers and the write-back mux; the CPU controller waits on done before popping/pushing.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
SHW, $clog2(WIDTH), shift-amount bits taken from alu_in2 for SHL

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when busy=0
alu_op  input  3  opcode, sampled with start
alu_in1  input  WIDTH  operand A, sampled with start
alu_in2  input  WIDTH  operand B, sampled with start
alu_out  output  WIDTH  registered result, held until next completion
busy  output  1  high while a multi-cycle op is in progress
done  output  1  one-cycle pulse when alu_out/flags update
zero  output  1  result == 0
carry  output  1  carry/borrow/overflow per op
neg  output  1  result MSB

Behaviour:
- Reset (async, any time incl. mid-multiply): state=IDLE, alu_out=0, busy=0, done=0, zero=0, carry=0, neg=0; partial product discarded.
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 NOT (~in1), 100 OR, 101 XOR, 110 SHL (in1 << in2[SHW-1:0]), 111 MUL (low WIDTH bits of in1*in2).
- States: IDLE, MUL. busy = (state==MUL).
- IDLE + start + op!=MUL: at next edge alu_out/flags load, done=1 for one cycle, stay IDLE. Latency 1.
- IDLE + start + op==MUL: at next edge capture operands, acc=0, count=0, -> MUL. Each MUL cycle: if multiplier LSB, acc += multiplicand (WIDTH*2-bit acc); multiplicand<<1, multiplier>>1, count++. On edge where count reaches WIDTH-1 step completes: alu_out=acc[WIDTH-1:0], flags load, done=1, -> IDLE. Total start-to-done latency WIDTH+1 edges.
- start while busy=1: ignored, no effect on operands or state.
- start asserted in the cycle done=1: accepted (busy already 0).
- done is 0 every cycle not listed above; alu_out and flags hold otherwise.
- Flags: zero = (result==0); neg = result[WIDTH-1]; carry: ADD = carry-out of WIDTH-bit sum; SUB = borrow (in1 < in2 unsigned); SHL = any 1 bit shifted out; MUL = acc[2*WIDTH-1:WIDTH] != 0; AND/NOT/OR/XOR = 0.
- All arithmetic unsigned modulo 2^WIDTH.

Optional Feature:
SEQ_ALU_MUL_EN. Defined: MUL as above, MUL state and multiplier present. Undefined: no MUL state/logic; op 111 completes in 1 cycle like others with alu_out=0, zero=1, carry=0, neg=0; busy permanently 0.

Decomposition:
- Package seq_alu_pkg: opcode localparams (OP_ADD..OP_MUL), state encoding (ST_IDLE, ST_MUL), flag bit-index constants.
- Sub-module seq_alu_mul (iterative shift-add core: load, step, acc, last) instantiated under SEQ_ALU_MUL_EN; single-cycle ops stay in seq_alu.

Test Plan:
- Reset then ADD, WIDTH=8: in1=0xF0, in2=0x20 -> next cycle alu_out=0x10, carry=1, zero=0, neg=0, done pulse 1 cycle.
- SUB 0x05-0x05 then 0x03-0x04 -> 0x00 zero=1 carry=0; then 0xFF carry=1 neg=1.
- SHL in1=0x81, in2=0x01 -> 0x02, carry=1; NOT 0x0F -> 0xF0 neg=1; AND/OR/XOR 0xCC,0xAA -> 0x88/0xEE/0x66.
- MUL 0x0D*0x0B -> busy high 8 cycles, done at edge 9, alu_out=0x8F, carry=0; MUL 0x10*0x10 -> 0x00, zero=1, carry=1.
- start pulsed with ADD during MUL busy -> ignored, MUL result unchanged; ADD issued on done cycle -> accepted, result next cycle.
- rst asserted at MUL cycle 4 -> all outputs 0 immediately, busy=0; subsequent ADD 1+1 -> 0x02. Repeat MUL test with macro undefined -> 1-cycle done, alu_out=0, zero=1.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared opcode, state and flag-index definitions for seq_alu.
package seq_alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    localparam int unsigned FLAG_ZERO  = 0;
    localparam int unsigned FLAG_CARRY = 1;
    localparam int unsigned FLAG_NEG   = 2;
    localparam int unsigned FLAG_W     = 3;

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative shift-add multiplier core: one partial product per step, full 2*WIDTH product.
module seq_alu_mul #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] prod_c,
    output logic               last_c
);
    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [W2-1:0]    mcand;
    logic [W2-1:0]    acc;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    count;

    // Accumulator value after the current step, so the final step is visible to the caller.
    assign prod_c = acc + (mplier[0] ? mcand : '0);
    assign last_c = (count == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            count  <= '0;
        end else if (load) begin
            mcand  <= W2'(a);
            acc    <= '0;
            mplier <= b;
            count  <= '0;
        end else if (step) begin
            acc    <= prod_c;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with flags; multi-cycle multiply enabled by SEQ_ALU_MUL_EN.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_in1,
    input  logic [WIDTH-1:0] alu_in2,
    output logic [WIDTH-1:0] alu_out,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic             carry,
    output logic             neg
);
    localparam int unsigned W2 = 2 * WIDTH;

    logic [FLAG_W-1:0] flags;
    logic [FLAG_W-1:0] flags_d;
    logic [WIDTH-1:0]  out_d;
    logic              done_d;
    logic [WIDTH-1:0]  res_c;
    logic              cy_c;
    logic [WIDTH:0]    sum_c;
    logic [WIDTH:0]    diff_c;
    logic [W2-1:0]     shl_c;

    function automatic logic [FLAG_W-1:0] pack_flags(input logic [WIDTH-1:0] r, input logic c);
        logic [FLAG_W-1:0] f;
        f             = '0;
        f[FLAG_ZERO]  = (r == '0);
        f[FLAG_CARRY] = c;
        f[FLAG_NEG]   = r[WIDTH-1];
        return f;
    endfunction

    assign sum_c  = {1'b0, alu_in1} + {1'b0, alu_in2};
    assign diff_c = {1'b0, alu_in1} - {1'b0, alu_in2};
    assign shl_c  = W2'(alu_in1) << alu_in2[SHW-1:0];

    // Single-cycle result; MUL falls through to zero, which is the disabled-multiplier result.
    always_comb begin
        res_c = '0;
        cy_c  = 1'b0;
        case (alu_op)
            OP_ADD: begin res_c = sum_c[WIDTH-1:0];  cy_c = sum_c[WIDTH];  end
            OP_SUB: begin res_c = diff_c[WIDTH-1:0]; cy_c = diff_c[WIDTH]; end
            OP_AND: res_c = alu_in1 & alu_in2;
            OP_NOT: res_c = ~alu_in1;
            OP_OR:  res_c = alu_in1 | alu_in2;
            OP_XOR: res_c = alu_in1 ^ alu_in2;
            OP_SHL: begin res_c = shl_c[WIDTH-1:0]; cy_c = |shl_c[W2-1:WIDTH]; end
            default: ;
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    state_t        state;
    state_t        state_d;
    logic          load_c;
    logic          step_c;
    logic [W2-1:0] prod_c;
    logic          last_c;

    seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
        .clk    (clk),
        .rst    (rst),
        .load   (load_c),
        .step   (step_c),
        .a      (alu_in1),
        .b      (alu_in2),
        .prod_c (prod_c),
        .last_c (last_c)
    );

    always_comb begin
        state_d = state;
        out_d   = alu_out;
        flags_d = flags;
        done_d  = 1'b0;
        load_c  = 1'b0;
        step_c  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (alu_op == OP_MUL) begin
                        load_c  = 1'b1;
                        state_d = ST_MUL;
                    end else begin
                        out_d   = res_c;
                        flags_d = pack_flags(res_c, cy_c);
                        done_d  = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                step_c = 1'b1;
                if (last_c) begin
                    out_d   = prod_c[WIDTH-1:0];
                    flags_d = pack_flags(prod_c[WIDTH-1:0], |prod_c[W2-1:WIDTH]);
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_d;
            busy  <= (state_d == ST_MUL);
        end
    end
`else
    always_comb begin
        out_d   = alu_out;
        flags_d = flags;
        done_d  = 1'b0;
        if (start) begin
            out_d   = res_c;
            flags_d = pack_flags(res_c, cy_c);
            done_d  = 1'b1;
        end
    end

    assign busy = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_out <= '0;
            flags   <= '0;
            done    <= 1'b0;
        end else begin
            alu_out <= out_d;
            flags   <= flags_d;
            done    <= done_d;
        end
    end

    assign zero  = flags[FLAG_ZERO];
    assign carry = flags[FLAG_CARRY];
    assign neg   = flags[FLAG_NEG];

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: transaction-level model checked every cycle plus directed literal checks.
module tb_seq_alu;
    localparam int unsigned W   = 8;
    localparam int unsigned SHW = 3;
`ifdef SEQ_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   alu_op = 3'd0;
    logic [W-1:0] alu_in1 = '0;
    logic [W-1:0] alu_in2 = '0;
    logic [W-1:0] alu_out;
    logic         busy, done, zero, carry, neg;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    seq_alu #(.WIDTH(W), .SHW(SHW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .alu_op  (alu_op),
        .alu_in1 (alu_in1),
        .alu_in2 (alu_in2),
        .alu_out (alu_out),
        .busy    (busy),
        .done    (done),
        .zero    (zero),
        .carry   (carry),
        .neg     (neg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the opcode table.
    function automatic void compute(input logic [2:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b, output logic [W-1:0] r,
                                    output logic c);
        logic [2*W-1:0] full;
        r = '0;
        c = 1'b0;
        case (op)
            3'd0: begin full = 16'(a) + 16'(b); r = full[W-1:0]; c = full[W]; end
            3'd1: begin r = a - b; c = (a < b); end
            3'd2: r = a & b;
            3'd3: r = ~a;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: begin full = 16'(a) << b[SHW-1:0]; r = full[W-1:0]; c = (full >> W) != 0; end
            default: if (MUL_EN) begin
                full = 16'(a) * 16'(b);
                r = full[W-1:0];
                c = (full >> W) != 0;
            end
        endcase
    endfunction

    // Model: pend counts edges left until a multiply completes.
    int           pend = 0;
    logic [W-1:0] m_out = '0, p_out = '0;
    logic         m_z = 1'b0, m_c = 1'b0, m_n = 1'b0, m_done = 1'b0, p_c = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend = 0; m_out = '0; m_z = 0; m_c = 0; m_n = 0; m_done = 0;
        end else begin
            m_done = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    m_out = p_out; m_c = p_c; m_z = (p_out == 0); m_n = p_out[W-1]; m_done = 1'b1;
                end
            end else if (start) begin
                compute(alu_op, alu_in1, alu_in2, p_out, p_c);
                if (MUL_EN && alu_op == 3'd7) pend = W;
                else begin
                    m_out = p_out; m_c = p_c; m_z = (p_out == 0); m_n = p_out[W-1]; m_done = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("done", 32'(done), 32'(m_done));
            chk("busy", 32'(busy), 32'(pend > 0));
            chk("alu_out", 32'(alu_out), 32'(m_out));
            chk("flags_zcn", 32'({zero, carry, neg}), 32'({m_z, m_c, m_n}));
        end
    end

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1; alu_op = op; alu_in1 = a; alu_in2 = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic expect1(input string name, input logic [W-1:0] r, input logic z,
                           input logic c, input logic n);
        chk({name, "_done"}, 32'(done), 32'd1);
        chk({name, "_out"}, 32'(alu_out), 32'(r));
        chk({name, "_zcn"}, 32'({zero, carry, neg}), 32'({z, c, n}));
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 32'(n), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out", 32'(alu_out), 32'd0);
        chk("rst_ctl", 32'({busy, done, zero, carry, neg}), 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        issue(3'd0, 8'hF0, 8'h20); expect1("add", 8'h10, 0, 1, 0);
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
        chk("hold_out", 32'(alu_out), 32'h10);
        issue(3'd1, 8'h05, 8'h05); expect1("sub0", 8'h00, 1, 0, 0);
        issue(3'd1, 8'h03, 8'h04); expect1("subb", 8'hFF, 0, 1, 1);
        issue(3'd6, 8'h81, 8'h01); expect1("shl", 8'h02, 0, 1, 0);
        issue(3'd3, 8'h0F, 8'h00); expect1("not", 8'hF0, 0, 0, 1);
        issue(3'd2, 8'hCC, 8'hAA); expect1("and", 8'h88, 0, 0, 1);
        issue(3'd4, 8'hCC, 8'hAA); expect1("or", 8'hEE, 0, 0, 1);
        issue(3'd5, 8'hCC, 8'hAA); expect1("xor", 8'h66, 0, 0, 0);

        issue(3'd7, 8'h0D, 8'h0B);
        if (MUL_EN) begin
            chk("mul_busy", 32'(busy), 32'd1);
            wait_done(n);
            chk("mul_latency", 32'(n), 32'd8);
            expect1("mul", 8'h8F, 0, 0, 1);
            issue(3'd7, 8'h10, 8'h10);
            wait_done(n);
            expect1("mul_ovf", 8'h00, 1, 1, 0);

            // ADD pulsed while busy is ignored.
            issue(3'd7, 8'h0D, 8'h0B);
            @(negedge clk);
            start = 1'b1; alu_op = 3'd0; alu_in1 = 8'h01; alu_in2 = 8'h01;
            @(negedge clk);
            start = 1'b0;
            wait_done(n);
            expect1("mul_ign", 8'h8F, 0, 0, 1);
            // ADD on the done cycle is accepted.
            start = 1'b1; alu_op = 3'd0; alu_in1 = 8'h01; alu_in2 = 8'h02;
            @(negedge clk);
            start = 1'b0;
            expect1("add_on_done", 8'h03, 0, 0, 0);

            // Reset in the middle of a multiply.
            issue(3'd7, 8'h0D, 8'h0B);
            repeat (3) @(negedge clk);
            #2 rst = 1'b1;
            #1;
            chk("midrst_out", 32'(alu_out), 32'd0);
            chk("midrst_ctl", 32'({busy, done, zero, carry, neg}), 32'd0);
            @(negedge clk);
            rst = 1'b0;
            issue(3'd0, 8'h01, 8'h01); expect1("add_after_rst", 8'h02, 0, 0, 0);
            repeat (12) @(negedge clk);
            chk("no_late_done", 32'(done), 32'd0);
        end else begin
            expect1("mul_off", 8'h00, 1, 0, 0);
            chk("mul_off_busy", 32'(busy), 32'd0);
            issue(3'd7, 8'h10, 8'h10); expect1("mul_off2", 8'h00, 1, 0, 0);
            issue(3'd0, 8'h01, 8'h01); expect1("add_after", 8'h02, 0, 0, 0);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
